// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - 16-bit-word data RAM responder with wait states, 32-bit split access and range faults
module data_mem_responder #(
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        i_reset_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic        i_en32,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_fault,
    output logic        o_busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC_LO, S_ACC_HI} state_t;

    state_t        state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic          we_q, we_d;
    logic          en32_q, en32_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    fault_pend_q, fault_pend_d;
    logic [15:0]   hi_word_q, hi_word_d;
    logic          ack_q, ack_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    fault_q, fault_d;

    logic [15:0]   mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;
    logic [AW-1:0] idx_hi;
    logic [15:0]   rd_lo, rd_hi;
    logic          range_bad;

    assign idx_hi = idx_q + AW'(1);
    assign rd_lo  = mem[idx_q];
    assign rd_hi  = mem[idx_hi];

    // Compare against DEPTH-1 for 32-bit so addr+1 can never wrap past zero
    assign range_bad = i_en32 ? (i_addr >= 32'(DEPTH - 1)) : (i_addr >= 32'(DEPTH));

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        we_d         = we_q;
        en32_d       = en32_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        fault_pend_d = fault_pend_q;
        hi_word_d    = hi_word_q;
        ack_d        = 1'b0;
        rdata_d      = rdata_q;
        fault_d      = 2'b00;
        mem_we       = 1'b0;
        mem_waddr    = idx_q;
        mem_wdata    = wdata_q[15:0];
        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    we_d         = i_we;
                    en32_d       = i_en32;
                    idx_d        = i_addr[AW-1:0];
                    wdata_d      = i_wdata;
                    wait_cnt_d   = 4'd0;
                    fault_pend_d = range_bad ? (i_we ? 2'b10 : 2'b01) : 2'b00;
                    state_d      = (range_bad || WAIT_STATES == 0) ? S_ACC_LO : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'(WAIT_STATES - 1)) begin
                    state_d = S_ACC_LO;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_ACC_LO: begin
                if (fault_pend_q != 2'b00) begin
                    ack_d   = 1'b1;
                    fault_d = fault_pend_q;
                    rdata_d = 32'd0;
                    state_d = S_IDLE;
                end else if (en32_q) begin
                    mem_we    = we_q;
                    mem_wdata = wdata_q[31:16];
                    hi_word_d = rd_lo;
                    state_d   = S_ACC_HI;
                end else begin
                    mem_we  = we_q;
                    ack_d   = 1'b1;
                    rdata_d = we_q ? 32'd0 : {16'h0000, rd_lo};
                    state_d = S_IDLE;
                end
            end
            S_ACC_HI: begin
                mem_we    = we_q;
                mem_waddr = idx_hi;
                ack_d     = 1'b1;
                rdata_d   = we_q ? 32'd0 : {hi_word_q, rd_hi};
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= 4'd0;
            we_q         <= 1'b0;
            en32_q       <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 32'd0;
            fault_pend_q <= 2'b00;
            hi_word_q    <= 16'd0;
            ack_q        <= 1'b0;
            rdata_q      <= 32'd0;
            fault_q      <= 2'b00;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            we_q         <= we_d;
            en32_q       <= en32_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            fault_pend_q <= fault_pend_d;
            hi_word_q    <= hi_word_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            fault_q      <= fault_d;
        end
    end

    // RAM keeps its contents across reset; an aborted access is blocked because state_q drops to IDLE
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign o_ack   = ack_q;
    assign o_rdata = rdata_q;
    assign o_fault = fault_q;
    assign o_busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder (WAIT_STATES 0 and 2)
module tb_data_mem_responder;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we_i = 1'b0, en32_i = 1'b0;
    logic [31:0] addr_i = 32'd0, wdata_i = 32'd0;
    logic        ack0, ack1, busy0, busy1;
    logic [31:0] rdata0, rdata1;
    logic [1:0]  fault0, fault1;

    int total = 0;
    int bad   = 0;
    logic [15:0] mm [2][DEPTH];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_w0 (
        .clk(clk), .i_reset_n(rst_n), .i_req(req0), .i_we(we_i), .i_en32(en32_i),
        .i_addr(addr_i), .i_wdata(wdata_i), .o_ack(ack0), .o_rdata(rdata0),
        .o_fault(fault0), .o_busy(busy0));

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(2)) u_w2 (
        .clk(clk), .i_reset_n(rst_n), .i_req(req1), .i_we(we_i), .i_en32(en32_i),
        .i_addr(addr_i), .i_wdata(wdata_i), .o_ack(ack1), .o_rdata(rdata1),
        .o_fault(fault1), .o_busy(busy1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic s_ack(input int d);   return (d == 0) ? ack0 : ack1;     endfunction
    function automatic logic s_busy(input int d);  return (d == 0) ? busy0 : busy1;   endfunction
    function automatic logic [31:0] s_rdata(input int d); return (d == 0) ? rdata0 : rdata1; endfunction
    function automatic logic [1:0] s_fault(input int d);  return (d == 0) ? fault0 : fault1; endfunction

    // One complete access on DUT d (0: no wait states, 1: two wait states), checked against the model
    task automatic op(input int d, input bit we, input bit e32, input logic [31:0] a, input logic [31:0] wd);
        logic [63:0] last;
        bit          f;
        int          lat, n, busy_n;
        logic [31:0] exp_rd;
        logic [1:0]  exp_f;
        last   = {32'd0, a} + (e32 ? 64'd1 : 64'd0);
        f      = (last >= 64'(DEPTH));
        exp_f  = f ? (we ? 2'b10 : 2'b01) : 2'b00;
        lat    = f ? 1 : ((d == 0) ? 0 : 2) + 1 + (e32 ? 1 : 0);
        exp_rd = 32'd0;
        if (!f && !we)
            exp_rd = e32 ? {mm[d][a[11:0]], mm[d][a[11:0] + 12'd1]} : {16'h0000, mm[d][a[11:0]]};
        @(negedge clk);
        we_i = we; en32_i = e32; addr_i = a; wdata_i = wd;
        if (d == 0) req0 = 1'b1; else req1 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        n = 0; busy_n = 0;
        while (n < 64) begin
            if (s_ack(d)) break;
            if (s_busy(d)) busy_n++;
            @(posedge clk); #1;
            n++;
        end
        check("ack_seen", 32'(s_ack(d)), 32'd1);
        check("latency", 32'(n), 32'(lat));
        check("busy_cycles", 32'(busy_n), 32'(lat));
        check("busy_at_ack", 32'(s_busy(d)), 32'd0);
        check("rdata", s_rdata(d), exp_rd);
        check("fault", 32'(s_fault(d)), 32'(exp_f));
        @(posedge clk); #1;
        check("ack_width", 32'(s_ack(d)), 32'd0);
        check("fault_clear", 32'(s_fault(d)), 32'd0);
        check("rdata_hold", s_rdata(d), exp_rd);
        if (!f && we) begin
            if (e32) begin
                mm[d][a[11:0]]         = wd[31:16];
                mm[d][a[11:0] + 12'd1] = wd[15:0];
            end else begin
                mm[d][a[11:0]] = wd[15:0];
            end
        end
    endtask

    initial begin
        int  d;
        bit  we, e;
        logic [31:0] a;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_rdata", rdata0, 32'd0);
        check("rst_fault", 32'(fault0), 32'd0);
        check("rst_busy_w2", 32'(busy1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i += 2) begin
            op(0, 1'b1, 1'b1, 32'(i), $urandom);
            op(1, 1'b1, 1'b1, 32'(i), $urandom);
        end

        op(0, 1'b1, 1'b0, 32'd5, 32'h0000BEEF);
        op(0, 1'b0, 1'b0, 32'd5, 32'd0);
        op(0, 1'b1, 1'b1, 32'h10, 32'h12345678);
        op(0, 1'b0, 1'b0, 32'h10, 32'd0);
        op(0, 1'b0, 1'b0, 32'h11, 32'd0);
        op(0, 1'b0, 1'b1, 32'h10, 32'd0);
        op(1, 1'b0, 1'b1, 32'h10, 32'd0);

        op(0, 1'b0, 1'b1, 32'(DEPTH - 1), 32'd0);
        op(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0000_7777);
        op(0, 1'b0, 1'b0, 32'd0, 32'd0);
        op(0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1111_2222);
        op(0, 1'b1, 1'b1, 32'(DEPTH - 2), 32'hCAFE_F00D);
        op(0, 1'b0, 1'b1, 32'(DEPTH - 2), 32'd0);
        op(1, 1'b1, 1'b0, 32'(DEPTH), 32'd0);

        // Abort a 32-bit write during its second word
        @(negedge clk);
        we_i = 1'b1; en32_i = 1'b1; addr_i = 32'h20; wdata_i = 32'hAAAA5555; req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_pre", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_ack", 32'(ack0), 32'd0);
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_rdata", rdata0, 32'd0);
        @(posedge clk); #1;
        check("abort_no_ack", 32'(ack0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mm[0][12'h20] = 16'hAAAA;
        op(0, 1'b0, 1'b0, 32'h20, 32'd0);
        op(0, 1'b0, 1'b0, 32'h21, 32'd0);

        // Held request: back-to-back reads, address changes while busy must be ignored
        @(negedge clk);
        we_i = 1'b0; en32_i = 1'b0; addr_i = 32'd1; req0 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            if (i < 3) addr_i = 32'(i + 1);
            else req0 = 1'b0;
            check("b2b_busy", 32'(busy0), 32'd1);
            check("b2b_noack", 32'(ack0), 32'd0);
            @(posedge clk); #1;
            check("b2b_ack", 32'(ack0), 32'd1);
            check("b2b_rdata", rdata0, {16'h0000, mm[0][i]});
        end

        for (int k = 0; k < 60; k++) begin
            d  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            we = 1'($urandom_range(0, 1));
            e  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       a = 32'hFFFF_FFFF;
                1:       a = 32'(DEPTH) + 32'($urandom_range(0, 3));
                default: a = e ? 32'($urandom_range(0, 62)) : 32'($urandom_range(0, 63));
            endcase
            op(d, we, e, a, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
